// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter FSM encoding and requester limit.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int ARB_MAX_REQ  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LAUNCH,
    ARB_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;
  int   cand;

  // Offsets run 1..N so the pointer's own index is examined last.
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr_i) + off) % N;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Defining UART_ARB_LOCK_EN adds req_lock so multi-byte packets stay contiguous.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ),
  localparam int DATA_W  = UART_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      active
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ out of range");
  end

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  ready_q;
  logic                start_q;
  logic                active_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    rr_ptr_q;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [NUM_REQ-1:0]  grant_onehot;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic lock_q;
  logic lock_hold;

  // A held lock only wins while its owner still has a byte; otherwise fall back to round-robin.
  assign lock_hold = lock_q && req_valid[grant_q];
  assign win_idx   = lock_hold ? grant_q : pick_idx;
  assign win_any   = lock_hold || pick_any;
`else
  assign win_idx   = pick_idx;
  assign win_any   = pick_any;
`endif

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ready_q  <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ-1);
`ifdef UART_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
`ifdef UART_ARB_LOCK_EN
          if (lock_q && !req_valid[grant_q]) lock_q <= 1'b0;
`endif
          if (win_any && !tx_busy) begin
            data_q   <= req_data[int'(win_idx)*DATA_W +: DATA_W];
            grant_q  <= win_idx;
            active_q <= 1'b1;
            state_q  <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          start_q <= 1'b1;
          ready_q <= grant_onehot;
`ifdef UART_ARB_LOCK_EN
          if (!lock_q) rr_ptr_q <= grant_q;
`else
          rr_ptr_q <= grant_q;
`endif
          state_q <= ARB_WAIT_DONE;
        end
        ARB_WAIT_DONE: begin
          start_q <= 1'b0;
          ready_q <= '0;
          if (tx_done) begin
            active_q <= 1'b0;
            state_q  <= ARB_IDLE;
`ifdef UART_ARB_LOCK_EN
            lock_q   <= req_lock[grant_q];
`endif
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign grant_idx = grant_q;
  assign active    = active_q;

endmodule
